act_requant: RTL and testbench
==============================

# act_requant

Downstream stage of the vectorized FMA: consumes VECTOR_WIDTH signed accumulator sums per transfer, then applies a rounding arithmetic right shift, optional ReLU and signed saturation. It produces narrow activations for the next layer's data input. A two-stage pipeline plus an output FIFO decouple the FMA from a stalling consumer through valid/ready handshakes on both sides.

## Interface
- VECTOR_WIDTH, 4, lanes per transfer
- IN_WIDTH, 16, signed width of incoming sums
- OUT_WIDTH, 8, signed width of produced activations
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)
- clk  in  1  clock; all logic on posedge
- rstn  in  1  reset, synchronous, active-low
- in_valid  in  1  sum_in/cfg valid
- in_ready  out  1  block can accept this cycle
- sum_in  in  VECTOR_WIDTH x IN_WIDTH signed  accumulator sums
- shift_amt  in  4  right-shift amount, 0..15, sampled with the vector
- relu_en  in  1  clamp negatives to 0, sampled with the vector
- out_valid  out  1  act_out holds FIFO head
- out_ready  in  1  consumer takes head this cycle
- act_out  out  VECTOR_WIDTH x OUT_WIDTH signed  activations
- count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
- clr_sat  in  1  clears sat_flag
- sat_flag  out  1  sticky: some lane saturated

## Operation
- Accept: transfer occurs on an edge where in_valid && in_ready. sum_in, shift_amt and relu_en are captured together.
- Stage 1 (registered, per lane): compute r = (x + (s>0 ? 1<<(s-1) : 0)) >>> s in IN_WIDTH+1 bits. This rounds half toward +inf and cannot overflow.
- Stage 2 (combinational into the FIFO write): if relu_en and r<0, then r=0. Clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. A clamp sets the per-vector sat bit.
- FIFO write: a valid stage-1 register is written into the FIFO on the next edge, unconditionally. Space is guaranteed by in_ready.
- in_ready = (count + s1_valid) < FIFO_DEPTH. It is computed from registered state only, with no combinational path from out_ready.
- Pop: occurs on an edge with out_valid && out_ready. act_out shows the FIFO head. out_valid = (count != 0).
- Simultaneous push and pop: occupancy is unchanged and pointers advance. At count==FIFO_DEPTH with a pop, no push can be pending because in_ready held s1 empty.
- Pointers wrap modulo FIFO_DEPTH.
- sat_flag sets on the edge a saturated vector is written into the FIFO. clr_sat clears it. If set and clear coincide, set wins.
- Order is strictly preserved; no lane reordering.

## Timing
- Reset (rstn=0 at an edge): s1_valid=0, count=0, pointers=0, sat_flag=0, out_valid=0, act_out=0. in_ready=0 while rstn is low and 1 on the first cycle after release.
- Reset mid-operation discards all in-flight and buffered vectors. Nothing is emitted afterward.
- Latency: a vector accepted at edge k is in s1 after k and written to the FIFO at k+1. out_valid is high in the cycle after k+1, with the FIFO empty and out_ready=1.
- Throughput: one vector per cycle while out_ready=1.
- With out_ready held low, exactly FIFO_DEPTH vectors are accepted, then in_ready=0.
- One pop restores in_ready the cycle after the pop edge.
- act_out and out_valid must remain stable while out_valid && !out_ready.

## Test plan
- Rounding: sum 296, shift 4, relu off -> 19. Sum -24, shift 4 -> -1. Sum 7, shift 0 -> 7. Each appears 2 edges after acceptance.
- ReLU: lanes {-300,100,-1,0}, shift 0, relu on -> {0,100,0,0}. sat_flag remains 0 only if no clamp; 100 fits.
- Saturation: lanes {5000,-5000,127,-128}, shift 0, relu off -> {127,-128,127,-128}. sat_flag=1 and stays 1 until clr_sat; set+clr in the same cycle leaves it 1.
- Backpressure: out_ready=0, in_valid=1 for 8 cycles with distinct vectors -> 4 accepted, count=4, in_ready=0. Then out_ready=1 -> the 4 vectors drain in order, and new accepts resume.
- Streaming: in_valid=out_ready=1 for 20 vectors -> 20 outputs in order, one per cycle after 2-cycle latency, no bubbles, count ≤1.
- Reset mid-stream: after 3 accepts with out_ready=0, assert rstn=0 for one edge -> count=0, out_valid=0, act_out=0, sat_flag=0. No stale vector appears afterwards.

Source files
------------

// File: rtl/act_requant_if.sv
// act_requant_if: input-sum and output-activation handshakes plus status of the requant stage.
interface act_requant_if #(
    parameter int VECTOR_WIDTH = 4,
    parameter int IN_WIDTH = 16,
    parameter int OUT_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
);
    logic in_valid, in_ready, relu_en;
    logic [VECTOR_WIDTH-1:0][IN_WIDTH-1:0] sum_in;
    logic [3:0] shift_amt;
    logic out_valid, out_ready;
    logic [VECTOR_WIDTH-1:0][OUT_WIDTH-1:0] act_out;
    logic [$clog2(FIFO_DEPTH+1)-1:0] count;
    logic clr_sat, sat_flag;
    modport master (
        output in_valid, sum_in, shift_amt, relu_en, out_ready, clr_sat,
        input in_ready, out_valid, act_out, count, sat_flag
    );
    modport slave (
        input in_valid, sum_in, shift_amt, relu_en, out_ready, clr_sat,
        output in_ready, out_valid, act_out, count, sat_flag
    );
endinterface

// File: rtl/act_requant.sv
// act_requant: rounding shift, optional ReLU and saturation of FMA sums, buffered in an output FIFO.
module act_requant #(
    parameter int VECTOR_WIDTH = 4,
    parameter int IN_WIDTH = 16,
    parameter int OUT_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rstn,
    act_requant_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic signed [IN_WIDTH:0] MAXV = (IN_WIDTH+1)'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH:0] MINV = ~MAXV;
    logic s1_valid, s1_relu, accept, pop;
    logic [VECTOR_WIDTH-1:0][IN_WIDTH:0] s1_r;
    logic [IN_WIDTH:0] bias;
    logic [VECTOR_WIDTH-1:0][OUT_WIDTH-1:0] wr_data;
    logic [VECTOR_WIDTH-1:0] lane_sat;
    logic [VECTOR_WIDTH-1:0][OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic sat_flag;
    // (1<<s)>>1 yields the half-LSB rounding bias, and zero when s is 0
    assign bias = ((IN_WIDTH+1)'(1) << bus.shift_amt) >> 1;
    assign bus.in_ready = rstn && ({1'b0, count} + (CW+1)'(s1_valid) < (CW+1)'(FIFO_DEPTH));
    assign accept = bus.in_valid && bus.in_ready;
    assign bus.out_valid = count != '0;
    assign pop = bus.out_valid && bus.out_ready;
    assign bus.act_out = bus.out_valid ? mem[rd_ptr] : '0;
    assign bus.count = count;
    assign bus.sat_flag = sat_flag;
    for (genvar i = 0; i < VECTOR_WIDTH; i++) begin : g_lane
        logic signed [IN_WIDTH:0] r, v;
        assign r = $signed(s1_r[i]);
        assign v = (s1_relu && r < 0) ? '0 : r;
        assign lane_sat[i] = v > MAXV || v < MINV;
        assign wr_data[i] = v > MAXV ? MAXV[OUT_WIDTH-1:0] : v < MINV ? MINV[OUT_WIDTH-1:0] : v[OUT_WIDTH-1:0];
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_relu <= bus.relu_en;
            for (int j = 0; j < VECTOR_WIDTH; j++)
                s1_r[j] <= ($signed({bus.sum_in[j][IN_WIDTH-1], bus.sum_in[j]}) + $signed(bias)) >>> bus.shift_amt;
        end
        if (s1_valid) mem[wr_ptr] <= wr_data;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            sat_flag <= 1'b0;
        end else begin
            s1_valid <= accept;
            count <= count + CW'(s1_valid) - CW'(pop);
            if (s1_valid) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            sat_flag <= (s1_valid && |lane_sat) || (sat_flag && !bus.clr_sat);
        end
    end
endmodule

// File: tb/tb_act_requant.sv
// tb_act_requant: random and directed stimulus against a queue-based reference of act_requant.
module tb_act_requant;
    logic clk, rstn, mon_on;
    int checks, errors;
    act_requant_if #(.VECTOR_WIDTH(4), .IN_WIDTH(16), .OUT_WIDTH(8), .FIFO_DEPTH(4)) bus ();
    act_requant #(.VECTOR_WIDTH(4), .IN_WIDTH(16), .OUT_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] vec16(int a0, int a1, int a2, int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    function automatic logic [31:0] vec8(int a0, int a1, int a2, int a3);
        return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    // Floor-divide rounding, then ReLU and clamp, done on plain integers
    task automatic ref_vec(input logic [63:0] s, input int sh, input bit relu,
                           output logic [31:0] v, output bit sat);
        sat = 0;
        for (int i = 0; i < 4; i++) begin
            int x, d, n, q;
            x = int'($signed(s[i*16 +: 16]));
            d = 1 << sh;
            n = x + (sh > 0 ? d / 2 : 0);
            q = n / d;
            if (n < 0 && q * d != n) q--;
            if (relu && q < 0) q = 0;
            if (q > 127) begin q = 127; sat = 1; end
            if (q < -128) begin q = -128; sat = 1; end
            v[i*8 +: 8] = 8'(q);
        end
    endtask

    logic [31:0] q[$];
    logic [31:0] s1vec;
    bit s1v, s1sat, exp_sat;
    always @(negedge clk) if (mon_on) begin
        int n;
        bit rdy, set;
        n = q.size();
        rdy = rstn && (n + int'(s1v)) < 4;
        chk("in_ready", bus.in_ready, rdy);
        chk("out_valid", bus.out_valid, n != 0);
        chk("count", bus.count, n);
        chk("act_out", bus.act_out, (n != 0) ? q[0] : 32'd0);
        chk("sat_flag", bus.sat_flag, exp_sat);
        if (!rstn) begin
            q.delete();
            s1v = 0;
            exp_sat = 0;
        end else begin
            set = s1v && s1sat;
            if (n != 0 && bus.out_ready) void'(q.pop_front());
            if (s1v) q.push_back(s1vec);
            exp_sat = set || (exp_sat && !bus.clr_sat);
            s1v = bus.in_valid && rdy;
            if (s1v) ref_vec(bus.sum_in, int'(bus.shift_amt), bus.relu_en, s1vec, s1sat);
        end
    end

    task automatic cyc(bit v, logic [63:0] s, int sh, bit relu, bit ordy, bit clr);
        bus.in_valid = v;
        bus.sum_in = s;
        bus.shift_amt = 4'(sh);
        bus.relu_en = relu;
        bus.out_ready = ordy;
        bus.clr_sat = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int k);
        for (int i = 0; i < k; i++) cyc(0, '0, 0, 0, 1, 0);
    endtask

    function automatic logic [63:0] rv();
        return {$urandom, $urandom};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        mon_on = 0;
        s1v = 0;
        exp_sat = 0;
        rstn = 0;
        bus.in_valid = 0;
        bus.sum_in = '0;
        bus.shift_amt = '0;
        bus.relu_en = 0;
        bus.out_ready = 0;
        bus.clr_sat = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        mon_on = 1;
        rstn = 1;
        #1 chk("rel_in_ready", bus.in_ready, 1);
        cyc(1, vec16(296, -24, 0, 0), 4, 0, 1, 0);
        cyc(1, vec16(7, 0, 0, 0), 0, 0, 1, 0);
        chk("round_a", bus.act_out, vec8(19, -1, 0, 0));
        cyc(0, '0, 0, 0, 1, 0);
        chk("round_b", bus.act_out, vec8(7, 0, 0, 0));
        idle(2);
        cyc(1, vec16(-300, 100, -1, 0), 0, 1, 1, 0);
        cyc(0, '0, 0, 0, 1, 0);
        chk("relu", bus.act_out, vec8(0, 100, 0, 0));
        chk("relu_sat", bus.sat_flag, 0);
        idle(2);
        cyc(1, vec16(5000, -5000, 127, -128), 0, 0, 1, 0);
        cyc(0, '0, 0, 0, 1, 0);
        chk("sat_vec", bus.act_out, vec8(127, -128, 127, -128));
        chk("sat_set", bus.sat_flag, 1);
        idle(2);
        chk("sat_sticky", bus.sat_flag, 1);
        cyc(1, vec16(5000, 0, 0, 0), 0, 0, 1, 0);
        cyc(0, '0, 0, 0, 1, 1);
        chk("sat_set_wins", bus.sat_flag, 1);
        cyc(0, '0, 0, 0, 1, 1);
        chk("sat_clr", bus.sat_flag, 0);
        idle(2);
        for (int i = 0; i < 8; i++) cyc(1, rv(), $urandom_range(0, 15), 1'($urandom), 0, 0);
        chk("bp_count", bus.count, 4);
        chk("bp_in_ready", bus.in_ready, 0);
        cyc(0, '0, 0, 0, 1, 0);
        chk("bp_resume", bus.in_ready, 1);
        idle(5);
        chk("bp_drained", bus.count, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, rv(), $urandom_range(0, 15), 1'($urandom), 1, 0);
            chk("stream_cnt", bus.count <= 1, 1);
        end
        idle(4);
        cyc(1, vec16(5000, 1, 2, 3), 0, 0, 0, 0);
        cyc(1, rv(), 3, 0, 0, 0);
        cyc(1, rv(), 5, 0, 0, 0);
        rstn = 0;
        cyc(0, '0, 0, 0, 0, 0);
        chk("mid_rst_count", bus.count, 0);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_act", bus.act_out, 0);
        chk("mid_rst_sat", bus.sat_flag, 0);
        rstn = 1;
        idle(4);
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 9) < 7, rv(), $urandom_range(0, 15), 1'($urandom),
                $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0);
        idle(8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
